// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner/tag types and the default ROM base for the memory arbiter
package mem_arb_pkg;
  typedef enum logic {CPU = 1'b0, DMA = 1'b1} owner_t;
  typedef struct packed {logic valid; owner_t owner;} rd_tag_t;
  localparam logic [15:0] DEF_ROM_BASE = 16'hF000;
endpackage

// File: rtl/arb_tag_pipe.sv
// arb_tag_pipe: DEPTH-stage read-owner tag shift register (clk, rst sync clear, d in, q out)
module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t d,
  output rd_tag_t q
);
  rd_tag_t [DEPTH-1:0] pipe;
  always_ff @(posedge clk) begin
    if (rst) pipe <= '0;
    else pipe <= {pipe[DEPTH-2:0], d};
  end
  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU/DMA arbiter for one memory port (ph1, reset; cpu_*/dma_* request+return; mem_* drive; rom_wr_err pulse)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          MEM_LAT        = 1,
  parameter int          MAX_CPU_STREAK = 4,
  parameter logic [15:0] ROM_BASE       = DEF_ROM_BASE
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        rom_wr_err
);
  localparam int SW = $clog2(MAX_CPU_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_CPU_STREAK);
  logic [SW-1:0] streak;
  logic [7:0] cpu_hold, dma_hold;
  logic rom_drop;
  rd_tag_t tag_in, tag_out;
  assign cpu_gnt = !reset && cpu_req && !(dma_req && streak == SMAX);
  assign dma_gnt = !reset && dma_req && !cpu_gnt;
  assign rom_drop = cpu_gnt && cpu_we && cpu_addr >= ROM_BASE;
  assign tag_in = '{valid: (cpu_gnt && !cpu_we) || (dma_gnt && !dma_we), owner: dma_gnt ? DMA : CPU};
  arb_tag_pipe #(.DEPTH(MEM_LAT + 1)) tags (
    .clk(ph1),
    .rst(reset),
    .d(tag_in),
    .q(tag_out)
  );
  assign cpu_rvalid = !reset && tag_out.valid && tag_out.owner == CPU;
  assign dma_rvalid = !reset && tag_out.valid && tag_out.owner == DMA;
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold;
  assign dma_rdata = dma_rvalid ? mem_rdata : dma_hold;
  always_ff @(posedge ph1) begin
    if (reset) begin
      streak     <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rom_wr_err <= 1'b0;
      cpu_hold   <= '0;
      dma_hold   <= '0;
    end else begin
      streak     <= (!dma_req || dma_gnt) ? '0 : (cpu_gnt && streak != SMAX) ? streak + SW'(1) : streak;
      mem_en     <= (cpu_gnt && !rom_drop) || dma_gnt;
      mem_we     <= cpu_gnt ? cpu_we && !rom_drop : dma_gnt && dma_we;
      rom_wr_err <= rom_drop;
      if (cpu_gnt || dma_gnt) begin
        mem_addr  <= cpu_gnt ? cpu_addr : dma_addr;
        mem_wdata <= cpu_gnt ? cpu_wdata : dma_wdata;
      end
      if (cpu_rvalid) cpu_hold <= mem_rdata;
      if (dma_rvalid) dma_hold <= mem_rdata;
    end
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared memory port (RAM plus 4 KB ROM at $F000-$FFFF) between two requesters: the 6502 core (requester 0) and a debug/DMA loader (requester 1).
- The debug/DMA loader preloads ROM/RAM and inspects RAM results, e.g. the RAM[21] check at end of test.
- Sits between core/loader and the mem block.
- Provides fixed read latency, starvation-bounded CPU priority, and ROM write protection for the CPU.

Parameters:
- MEM_LAT, 1: memory read latency in cycles (1..3).
- MAX_CPU_STREAK, 4: maximum consecutive CPU grants while DMA is pending.
- ROM_BASE, 16'hF000: first ROM address; ROM occupies ROM_BASE..16'hFFFF.

Ports:
- ph1, in, 1: the single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- cpu_req, in, 1: CPU access request.
- cpu_we, in, 1: CPU write enable.
- cpu_addr, in, 16: CPU address.
- cpu_wdata, in, 8: CPU write data.
- cpu_gnt, out, 1: CPU request accepted this cycle.
- cpu_rvalid, out, 1: CPU read data valid.
- cpu_rdata, out, 8: CPU read data.
- dma_req, in, 1: DMA access request.
- dma_we, in, 1: DMA write enable.
- dma_addr, in, 16: DMA address.
- dma_wdata, in, 8: DMA write data.
- dma_gnt, out, 1: DMA request accepted this cycle.
- dma_rvalid, out, 1: DMA read data valid.
- dma_rdata, out, 8: DMA read data.
- mem_en, out, 1: memory access strobe.
- mem_we, out, 1: memory write strobe.
- mem_addr, out, 16: memory address.
- mem_wdata, out, 8: memory write data.
- mem_rdata, in, 8: memory read data, valid MEM_LAT cycles after mem_en with mem_we=0.
- rom_wr_err, out, 1: one-cycle pulse when a CPU write to ROM is dropped.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, streak counter 0, read-tag pipeline cleared. In-flight reads are discarded; no rvalid is produced for them after reset.
- Grant logic is combinational from the current req inputs and registered state:
  - At most one gnt per cycle.
  - A request is accepted in the cycle gnt=1.
  - Requester holds req/we/addr/wdata stable until gnt.
- Priority:
  - CPU wins unless dma_req=1 and streak==MAX_CPU_STREAK; then DMA wins.
  - DMA wins whenever cpu_req=0.
- Streak counter:
  - +1 on each CPU grant while dma_req=1, saturating at MAX_CPU_STREAK.
  - Cleared on any DMA grant or any cycle with dma_req=0.
- Memory drive: mem_en/mem_we/mem_addr/mem_wdata are registered copies of the granted request, asserted the cycle after gnt. When nothing is granted, mem_en=0, mem_we=0, and addr/wdata hold their previous value.
- ROM protection:
  - CPU write with cpu_addr >= ROM_BASE: granted normally.
  - mem_we forced 0 and mem_en forced 0 for that slot.
  - rom_wr_err pulses in the same cycle the slot would have been driven.
  - DMA writes to ROM pass through.
- Read return:
  - Each granted read pushes an owner tag (valid, id) into a MEM_LAT+1-deep shift register.
  - When the tag exits, the owner's rvalid=1 for one cycle and rdata=mem_rdata.
  - The other requester's rdata holds its last value.
  - Writes push an invalid tag.
- Latency: gnt at cycle N -> mem_en at N+1 -> rvalid at N+1+MEM_LAT.
- Throughput: back-to-back grants allowed every cycle; reads return in grant order.
- Address wraps naturally at 16 bits; no address checking beyond the ROM decode.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef owner_t (CPU=0, DMA=1).
  - typedef struct rd_tag_t {valid, owner}.
  - localparam ROM_BASE default.
- One sub-module, arb_tag_pipe: parameterised depth shift register of rd_tag_t with synchronous clear.

Test Plan:
- CPU-only read: cpu_req with addr $FFFD, ROM[$FFD]=$F0 at MEM_LAT=1 -> cpu_gnt at N, mem_en/addr=$FFFD at N+1, cpu_rvalid with rdata=$F0 at N+2; dma_rvalid stays 0.
- DMA write then CPU read: DMA writes $7F to $0015, then CPU reads $0015 -> mem_we=1 on the DMA slot; cpu_rdata=$7F.
- Starvation bound: cpu_req and dma_req held high continuously, MAX_CPU_STREAK=4 -> grant pattern C,C,C,C,D repeating; streak returns to 0 after each D.
- CPU ROM write: CPU writes $AA to $F010 -> cpu_gnt=1, mem_en=0, rom_wr_err pulses once, ROM unchanged. DMA write of $AA to $F010 -> mem_we=1.
- Interleaved reads, MEM_LAT=2: reads C@$0001, D@$0002, C@$0003 granted on consecutive cycles -> rvalids on consecutive cycles with owners C,D,C and correct data.
- Reset mid-read: reset asserted one cycle after a CPU read grant -> no cpu_rvalid afterwards, all outputs 0 during reset, first post-reset grant goes to CPU.
